// File: rtl/lap_holder_pkg.sv
// Shared mode encoding for the lap holder block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lap_holder_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    LIVE   = 2'd0,
    FREEZE = 2'd1,
    RECALL = 2'd2
  } mode_t;

endpackage

// File: rtl/lap_holder_if.sv
// Control/status bundle between a lap holder and its driver.
// Latency: n/a (wires only).
// Backpressure: none; strobes are single-cycle and always accepted.
interface lap_holder_if #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
);
  import lap_holder_pkg::*;

  logic [WIDTH-1:0] data_in;
  logic             pause;
  logic             lap;
  logic             recall;
  logic             clear;
  logic [WIDTH-1:0] data_out;
  mode_t            mode;
  logic [AW:0]      lap_cnt;
  logic [AW-1:0]    rd_idx;
  logic             full;
  logic             overflow;

  modport master (
    output data_in, pause, lap, recall, clear,
    input  data_out, mode, lap_cnt, rd_idx, full, overflow
  );

  modport slave (
    input  data_in, pause, lap, recall, clear,
    output data_out, mode, lap_cnt, rd_idx, full, overflow
  );

endinterface

// File: rtl/lap_holder_store.sv
// Lap entry storage: DEPTH x WIDTH registers, no reset (contents survive clear/reset).
// Latency: write visible on the cycle after the write edge; read is combinational.
// Backpressure: none; one write per cycle accepted unconditionally.
module lap_store #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // capture a lap into its physical slot
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lap_holder.sv
// Stopwatch display holder: live/freeze display, lap capture into a ring, and lap playback.
// Latency: data_out is combinational from data_in/hold_reg/store; state updates on the next edge.
// Backpressure: none; every strobe is acted on (or deliberately ignored) in its own cycle.
module lap_holder
  import lap_holder_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  lap_holder_if.slave bus
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_IDX = AW'(1);

  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] rd_dat;
  logic [WIDTH-1:0] data_out_c;

  mode_t            mode_q, mode_n;
  logic [AW:0]      lap_cnt_q, lap_cnt_n;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_n;
  logic [AW-1:0]    rd_idx_q, rd_idx_n;
  logic [AW-1:0]    oldest;
  logic [AW-1:0]    rd_addr;
  logic             ovf_q, ovf_n;
  logic             full_c;
  logic             has_laps;
  logic             at_last;
  logic             lap_we;
  mode_t            exit_mode;

  assign full_c    = (lap_cnt_q == DEPTH_CNT);
  assign has_laps  = (lap_cnt_q != '0);
  assign at_last   = ({1'b0, rd_idx_q} == (lap_cnt_q - ONE_CNT));
  assign exit_mode = bus.pause ? FREEZE : LIVE;

  // once the ring has wrapped, the oldest entry is the one about to be overwritten
  assign oldest  = full_c ? wr_ptr_q : '0;
  assign rd_addr = oldest + rd_idx_q;

  // a lap is dropped during playback, when it collides with recall, or when clear wins
  assign lap_we = bus.lap && !bus.recall && !bus.clear && (mode_q != RECALL);

  // hold register tracks the live count unless paused, regardless of mode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_reg <= '0;
    end else if (!bus.pause) begin
      hold_reg <= bus.data_in;
    end
  end

  // mode, pointer and counter state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= LIVE;
      lap_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_idx_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      mode_q    <= mode_n;
      lap_cnt_q <= lap_cnt_n;
      wr_ptr_q  <= wr_ptr_n;
      rd_idx_q  <= rd_idx_n;
      ovf_q     <= ovf_n;
    end
  end

  // next-state: clear dominates, then mode transitions, then lap capture
  always_comb begin
    mode_n    = mode_q;
    lap_cnt_n = lap_cnt_q;
    wr_ptr_n  = wr_ptr_q;
    rd_idx_n  = rd_idx_q;
    ovf_n     = ovf_q;

    if (bus.clear) begin
      mode_n    = exit_mode;
      lap_cnt_n = '0;
      wr_ptr_n  = '0;
      rd_idx_n  = '0;
      ovf_n     = 1'b0;
    end else begin
      case (mode_q)
        LIVE, FREEZE: begin
          if (bus.recall && has_laps) begin
            mode_n   = RECALL;
            rd_idx_n = '0;
          end else begin
            mode_n = exit_mode;
          end
        end
        RECALL: begin
          // pause only selects where playback returns to
          if (bus.recall) begin
            if (at_last) begin
              mode_n   = exit_mode;
              rd_idx_n = '0;
            end else begin
              rd_idx_n = rd_idx_q + ONE_IDX;
            end
          end
        end
        default: mode_n = LIVE;
      endcase

      if (lap_we) begin
        wr_ptr_n = wr_ptr_q + ONE_IDX;
        if (full_c) begin
          ovf_n = 1'b1;
        end else begin
          lap_cnt_n = lap_cnt_q + ONE_CNT;
        end
      end
    end
  end

  // displayed value selected by mode with no added latency
  always_comb begin
    data_out_c = bus.data_in;
    case (mode_q)
      LIVE:    data_out_c = bus.data_in;
      FREEZE:  data_out_c = hold_reg;
      RECALL:  data_out_c = rd_dat;
      default: data_out_c = bus.data_in;
    endcase
  end

  lap_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_store (
    .clk   (clk),
    .we    (lap_we),
    .waddr (wr_ptr_q),
    .wdata (data_out_c),
    .raddr (rd_addr),
    .rdata (rd_dat)
  );

  assign bus.data_out = data_out_c;
  assign bus.mode     = mode_q;
  assign bus.lap_cnt  = lap_cnt_q;
  assign bus.rd_idx   = rd_idx_q;
  assign bus.full     = full_c;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_lap_holder.sv
// Directed bench for lap_holder at WIDTH=11, DEPTH=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Expected values are hand-computed constants.
module tb_lap_holder;
  import lap_holder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;

  lap_holder_if #(.WIDTH(11), .DEPTH(4)) bus ();

  lap_holder #(.WIDTH(11), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lap(input int v);
    bus.data_in = 11'(v);
    bus.lap = 1'b1;
    tick();
    bus.lap = 1'b0;
  endtask

  task automatic do_recall();
    bus.recall = 1'b1;
    tick();
    bus.recall = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.data_in = 11'd123;
    bus.pause = 1'b0; bus.lap = 1'b0; bus.recall = 1'b0; bus.clear = 1'b0;
    #2;
    vecs++; if (bus.mode !== LIVE) begin errs++; $display("FAIL rst_mode got %0d want 0", bus.mode); end
    vecs++; if (bus.data_out !== 11'd123) begin errs++; $display("FAIL rst_data_out got %0d want 123", bus.data_out); end
    vecs++; if (bus.lap_cnt !== 3'd0) begin errs++; $display("FAIL rst_lap_cnt got %0d want 0", bus.lap_cnt); end
    vecs++; if (bus.full !== 1'b0 || bus.overflow !== 1'b0) begin errs++; $display("FAIL rst_flags got full=%b ovf=%b want 0 0", bus.full, bus.overflow); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    vecs++; if (bus.mode !== LIVE) begin errs++; $display("FAIL rel_mode got %0d want 0", bus.mode); end
    vecs++; if (bus.data_out !== 11'd123) begin errs++; $display("FAIL rel_data_out got %0d want 123", bus.data_out); end
    vecs++; if (bus.lap_cnt !== 3'd0) begin errs++; $display("FAIL rel_lap_cnt got %0d want 0", bus.lap_cnt); end
  endtask

  task automatic test_freeze();
    bus.data_in = 11'd50; bus.pause = 1'b0;
    tick();
    bus.pause = 1'b1; bus.data_in = 11'd60;
    tick();
    vecs++; if (bus.mode !== FREEZE) begin errs++; $display("FAIL frz_mode got %0d want 1", bus.mode); end
    vecs++; if (bus.data_out !== 11'd50) begin errs++; $display("FAIL frz_data_out got %0d want 50", bus.data_out); end
    bus.pause = 1'b0;
    #1;
    vecs++; if (bus.data_out !== 11'd50) begin errs++; $display("FAIL frz_hold_pre_edge got %0d want 50", bus.data_out); end
    tick();
    vecs++; if (bus.mode !== LIVE) begin errs++; $display("FAIL unfrz_mode got %0d want 0", bus.mode); end
    vecs++; if (bus.data_out !== 11'd60) begin errs++; $display("FAIL unfrz_data_out got %0d want 60", bus.data_out); end
  endtask

  task automatic test_laps();
    int expv [3] = '{10, 20, 30};
    do_clear();
    do_recall();
    vecs++; if (bus.mode !== LIVE) begin errs++; $display("FAIL empty_recall_mode got %0d want 0", bus.mode); end
    do_lap(10); do_lap(20); do_lap(30);
    vecs++; if (bus.lap_cnt !== 3'd3 || bus.full !== 1'b0) begin errs++; $display("FAIL laps_cnt got %0d full=%b want 3 0", bus.lap_cnt, bus.full); end
    bus.data_in = 11'd999;
    for (int i = 0; i < 3; i++) begin
      do_recall();
      vecs++; if (bus.mode !== RECALL || bus.rd_idx !== 2'(i)) begin errs++; $display("FAIL rec_state[%0d] got mode=%0d idx=%0d want 2 %0d", i, bus.mode, bus.rd_idx, i); end
      vecs++; if (bus.data_out !== 11'(expv[i])) begin errs++; $display("FAIL rec_data[%0d] got %0d want %0d", i, bus.data_out, expv[i]); end
    end
    do_recall();
    vecs++; if (bus.mode !== LIVE || bus.rd_idx !== 2'd0) begin errs++; $display("FAIL rec_exit got mode=%0d idx=%0d want 0 0", bus.mode, bus.rd_idx); end
    vecs++; if (bus.data_out !== 11'd999) begin errs++; $display("FAIL rec_exit_data got %0d want 999", bus.data_out); end
  endtask

  task automatic test_overflow();
    int expv [4] = '{2, 3, 4, 5};
    do_clear();
    for (int v = 1; v <= 5; v++) begin
      do_lap(v);
      if (v == 4) begin
        vecs++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0 || bus.lap_cnt !== 3'd4) begin errs++; $display("FAIL full_edge got full=%b ovf=%b cnt=%0d want 1 0 4", bus.full, bus.overflow, bus.lap_cnt); end
      end
    end
    vecs++; if (bus.full !== 1'b1 || bus.overflow !== 1'b1 || bus.lap_cnt !== 3'd4) begin errs++; $display("FAIL ovf_state got full=%b ovf=%b cnt=%0d want 1 1 4", bus.full, bus.overflow, bus.lap_cnt); end
    bus.data_in = 11'd0;
    for (int i = 0; i < 4; i++) begin
      do_recall();
      vecs++; if (bus.mode !== RECALL || bus.data_out !== 11'(expv[i])) begin errs++; $display("FAIL ovf_rec[%0d] got mode=%0d data=%0d want 2 %0d", i, bus.mode, bus.data_out, expv[i]); end
    end
    do_recall();
    vecs++; if (bus.mode !== LIVE || bus.overflow !== 1'b1) begin errs++; $display("FAIL ovf_exit got mode=%0d ovf=%b want 0 1", bus.mode, bus.overflow); end
    do_clear();
    vecs++; if (bus.overflow !== 1'b0 || bus.full !== 1'b0 || bus.lap_cnt !== 3'd0) begin errs++; $display("FAIL ovf_clear got ovf=%b full=%b cnt=%0d want 0 0 0", bus.overflow, bus.full, bus.lap_cnt); end
  endtask

  task automatic test_priority();
    do_lap(7); do_lap(8);
    bus.data_in = 11'd77; bus.lap = 1'b1; bus.recall = 1'b1;
    tick();
    bus.lap = 1'b0; bus.recall = 1'b0;
    vecs++; if (bus.mode !== RECALL || bus.lap_cnt !== 3'd2) begin errs++; $display("FAIL lap_recall got mode=%0d cnt=%0d want 2 2", bus.mode, bus.lap_cnt); end
    vecs++; if (bus.data_out !== 11'd7) begin errs++; $display("FAIL lap_recall_data got %0d want 7", bus.data_out); end
    bus.pause = 1'b1;
    tick();
    vecs++; if (bus.mode !== RECALL) begin errs++; $display("FAIL rec_pause_mode got %0d want 2", bus.mode); end
    bus.lap = 1'b1;
    tick();
    bus.lap = 1'b0;
    vecs++; if (bus.lap_cnt !== 3'd2) begin errs++; $display("FAIL rec_lap_ignored got %0d want 2", bus.lap_cnt); end
    do_recall();
    vecs++; if (bus.data_out !== 11'd8 || bus.rd_idx !== 2'd1) begin errs++; $display("FAIL rec_step got data=%0d idx=%0d want 8 1", bus.data_out, bus.rd_idx); end
    do_recall();
    vecs++; if (bus.mode !== FREEZE || bus.data_out !== 11'd77) begin errs++; $display("FAIL rec_exit_frz got mode=%0d data=%0d want 1 77", bus.mode, bus.data_out); end
    bus.pause = 1'b0;
    tick();
    bus.data_in = 11'd55; bus.lap = 1'b1; bus.recall = 1'b1; bus.clear = 1'b1;
    tick();
    bus.lap = 1'b0; bus.recall = 1'b0; bus.clear = 1'b0;
    vecs++; if (bus.lap_cnt !== 3'd0 || bus.mode !== LIVE || bus.rd_idx !== 2'd0) begin errs++; $display("FAIL clr_prio got cnt=%0d mode=%0d idx=%0d want 0 0 0", bus.lap_cnt, bus.mode, bus.rd_idx); end
    bus.pause = 1'b1;
    do_clear();
    vecs++; if (bus.mode !== FREEZE) begin errs++; $display("FAIL clr_paused_mode got %0d want 1", bus.mode); end
    bus.pause = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    do_clear();
    do_lap(100); do_lap(200); do_lap(300);
    do_recall(); do_recall(); do_recall();
    vecs++; if (bus.mode !== RECALL || bus.rd_idx !== 2'd2 || bus.data_out !== 11'd300) begin errs++; $display("FAIL pre_arst got mode=%0d idx=%0d data=%0d want 2 2 300", bus.mode, bus.rd_idx, bus.data_out); end
    #2;
    rst = 1'b0;
    #1;
    vecs++; if (bus.mode !== LIVE || bus.rd_idx !== 2'd0 || bus.lap_cnt !== 3'd0) begin errs++; $display("FAIL arst_now got mode=%0d idx=%0d cnt=%0d want 0 0 0", bus.mode, bus.rd_idx, bus.lap_cnt); end
    bus.data_in = 11'd321;
    #1;
    vecs++; if (bus.data_out !== 11'd321) begin errs++; $display("FAIL arst_data got %0d want 321", bus.data_out); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    do_recall();
    vecs++; if (bus.mode !== LIVE || bus.lap_cnt !== 3'd0) begin errs++; $display("FAIL post_arst got mode=%0d cnt=%0d want 0 0", bus.mode, bus.lap_cnt); end
  endtask

  initial begin
    test_reset();
    test_freeze();
    test_laps();
    test_overflow();
    test_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/lap_holder.md
LAP_HOLDER -- requirements
Module: lap_holder

Interface
REQ-001 Parameter WIDTH, default 11: data bit width, minimum 1.
REQ-002 Parameter DEPTH, default 4: number of lap entries; a power of two, minimum 2; AW = clog2(DEPTH).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 data_in  input  WIDTH  live count value.
REQ-006 pause  input  1  level; 1 freezes the displayed value.
REQ-007 lap  input  1  one-cycle strobe; stores the displayed value.
REQ-008 recall  input  1  one-cycle strobe; enters or steps lap playback.
REQ-009 clear  input  1  one-cycle strobe; empties the lap store.
REQ-010 data_out  output  WIDTH  displayed value.
REQ-011 mode  output  2  current mode: LIVE=0, FREEZE=1, RECALL=2.
REQ-012 lap_cnt  output  AW+1  number of valid stored laps, 0..DEPTH.
REQ-013 rd_idx  output  AW  logical index of the recalled lap; 0 = oldest.
REQ-014 full  output  1  high when lap_cnt equals DEPTH.
REQ-015 overflow  output  1  sticky; set when a lap overwrites the oldest entry.

Function
REQ-016 hold_reg SHALL load data_in on every edge with pause=0, in every mode, and keep its value while pause=1.
REQ-017 data_out SHALL be combinational, with no added latency: data_in in LIVE, hold_reg in FREEZE, the stored entry at rd_idx in RECALL.
REQ-018 LIVE SHALL go to FREEZE on an edge with pause=1; FREEZE SHALL go to LIVE on an edge with pause=0.
REQ-019 On recall=1 in LIVE or FREEZE with lap_cnt>0, the block SHALL enter RECALL with rd_idx=0; recall with lap_cnt=0 SHALL be ignored.
REQ-020 In RECALL, recall=1 SHALL increment rd_idx; when rd_idx equals lap_cnt-1, recall SHALL instead exit to FREEZE if pause=1, else to LIVE, and rd_idx SHALL return to 0.
REQ-021 pause changes in RECALL SHALL NOT change mode; they only choose the exit mode.
REQ-022 lap=1 in LIVE or FREEZE SHALL write the current data_out to physical slot wr_ptr; wr_ptr SHALL wrap modulo DEPTH; the entry SHALL be readable from the next cycle.
REQ-023 lap_cnt SHALL saturate at DEPTH; a lap while full SHALL overwrite the oldest entry and set overflow.
REQ-024 The physical read address SHALL be (oldest + rd_idx) mod DEPTH, where oldest is wr_ptr when full and 0 otherwise.
REQ-025 lap SHALL be ignored in RECALL, and ignored in any cycle with recall=1.
REQ-026 clear SHALL take priority over lap and recall. It SHALL set lap_cnt=0, wr_ptr=0, rd_idx=0, overflow=0, and set mode to FREEZE if pause=1, else LIVE. hold_reg SHALL be unaffected.
REQ-027 Stored entries SHALL NOT be cleared by clear or reset; they are unreachable while lap_cnt=0.

Reset
REQ-028 While rst=0: mode=LIVE, hold_reg=0, lap_cnt=0, wr_ptr=0, rd_idx=0, full=0, overflow=0; data_out therefore follows data_in.
REQ-029 rst asserted mid-operation (any mode) SHALL apply REQ-028 immediately, without a clock edge.
REQ-030 Deassertion SHALL take effect at the first rising edge of clk after rst returns high.

Structure
REQ-031 A shared package SHALL hold the mode encoding constants (LIVE, FREEZE, RECALL) and the 2-bit mode type.
REQ-032 Storage SHALL be one sub-module, lap_store: a DEPTH x WIDTH register array with one synchronous write port and one combinational read port, no reset.
REQ-033 The mode FSM, pointers, counters and output mux SHALL reside in lap_holder.

Verification (WIDTH=11, DEPTH=4)
REQ-034 Reset release, data_in=123, no strobes -> mode=0, data_out=123, lap_cnt=0.
REQ-035 data_in=50 with pause=0, then pause=1 and data_in=60 -> mode=1, data_out=50; pause=0 -> data_out=60.
REQ-036 Laps at data_in 10, 20, 30; recall x4 -> data_out 10, 20, 30, then mode=0.
REQ-037 Laps at 1..5 -> full=1, overflow=1, lap_cnt=4; recall x4 -> data_out 2, 3, 4, 5.
REQ-038 lap, recall and clear asserted together with lap_cnt=2 -> lap_cnt=0, mode=LIVE, no write.
REQ-039 rst=0 asserted mid-RECALL at rd_idx=2 -> mode=0, rd_idx=0, lap_cnt=0 immediately, before the next clock edge.
